// File: rtl/rgb_frame_loader_if.sv
// Host byte stream and committed PL9823 colour bus for rgb_frame_loader.
// valid/ready: a byte moves on a rising edge where in_valid and in_ready are both 1; in_sof and in_data are only meaningful when in_valid is 1.
interface rgb_frame_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_sof;
    logic       in_ready;
    logic [7:0] D1_ROT;
    logic [7:0] D1_GRUEN;
    logic [7:0] D1_BLAU;
    logic [7:0] D2_ROT;
    logic [7:0] D2_GRUEN;
    logic [7:0] D2_BLAU;
    logic [7:0] D3_ROT;
    logic [7:0] D3_GRUEN;
    logic [7:0] D3_BLAU;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] dbg_state;

    modport slave (
        input  in_data, in_valid, in_sof,
        output in_ready,
        output D1_ROT, D1_GRUEN, D1_BLAU, D2_ROT, D2_GRUEN, D2_BLAU, D3_ROT, D3_GRUEN, D3_BLAU,
        output frame_done, frame_err, dbg_state
    );

    modport master (
        output in_data, in_valid, in_sof,
        input  in_ready,
        input  D1_ROT, D1_GRUEN, D1_BLAU, D2_ROT, D2_GRUEN, D2_BLAU, D3_ROT, D3_GRUEN, D3_BLAU,
        input  frame_done, frame_err, dbg_state
    );
endinterface

// File: rtl/rgb_frame_loader.sv
// Collects 9-byte RGB frames into shadow registers and commits them atomically to the
// three-LED colour outputs; partial frames are dropped on a new sof or an inter-byte timeout.
module rgb_frame_loader #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    rgb_frame_loader_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Timeout fires on the idle edge that would bring the count to TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] LP_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [3:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_shadow [0:8];
    logic [7:0]       r_d      [0:8];
    logic             r_ready;
    logic             r_done;
    logic             r_err;
    logic             w_xfer;

    assign w_xfer = bus.in_valid & r_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                r_shadow[i] <= 8'h00;
                r_d[i]      <= 8'h00;
            end
        end else begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ready <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= 4'd0;
                    if (w_xfer) begin
                        if (bus.in_sof) begin
                            r_shadow[0] <= bus.in_data;
                            r_idx       <= 4'd1;
                            r_state     <= ST_LOAD;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_xfer) begin
                        r_cnt <= '0;
                        if (bus.in_sof) begin
                            r_err       <= 1'b1;
                            r_shadow[0] <= bus.in_data;
                            r_idx       <= 4'd1;
                        end else begin
                            r_shadow[r_idx] <= bus.in_data;
                            if (r_idx == 4'd8) begin
                                r_idx   <= 4'd0;
                                r_ready <= 1'b0;
                                r_state <= ST_COMMIT;
                            end else begin
                                r_idx <= r_idx + 4'd1;
                            end
                        end
                    end else if (r_cnt >= LP_TO_LAST) begin
                        r_err   <= 1'b1;
                        r_cnt   <= '0;
                        r_idx   <= 4'd0;
                        r_state <= ST_IDLE;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_COMMIT: begin
                    for (int i = 0; i < 9; i++) begin
                        r_d[i] <= r_shadow[i];
                    end
                    r_done  <= 1'b1;
                    r_idx   <= 4'd0;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_idx   <= 4'd0;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_ready;
    assign bus.frame_done = r_done;
    assign bus.frame_err  = r_err;
    assign bus.dbg_state  = r_state;

    assign bus.D1_ROT   = r_d[0];
    assign bus.D1_GRUEN = r_d[1];
    assign bus.D1_BLAU  = r_d[2];
    assign bus.D2_ROT   = r_d[3];
    assign bus.D2_GRUEN = r_d[4];
    assign bus.D2_BLAU  = r_d[5];
    assign bus.D3_ROT   = r_d[6];
    assign bus.D3_GRUEN = r_d[7];
    assign bus.D3_BLAU  = r_d[8];

endmodule

// File: tb/tb_rgb_frame_loader.sv
// Directed and randomized bench for rgb_frame_loader against a queue-based frame model.
module tb_rgb_frame_loader;
    localparam int TO = 20;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    rgb_frame_loader_if bus();

    rgb_frame_loader #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Reference model: bytes of the frame in progress, committed colours, idle count.
    logic [7:0] m_d     [9];
    logic [7:0] m_frame [9];
    logic [7:0] part_q  [$];
    int         m_idle;
    bit         m_commit, m_ready, m_done, m_err;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [71:0] exp_d, obs_d;
        for (int i = 0; i < 9; i++) exp_d[71-8*i -: 8] = m_d[i];
        obs_d = {bus.D1_ROT, bus.D1_GRUEN, bus.D1_BLAU, bus.D2_ROT, bus.D2_GRUEN,
                 bus.D2_BLAU, bus.D3_ROT, bus.D3_GRUEN, bus.D3_BLAU};
        check("d_outputs", obs_d, exp_d);
        check("frame_done", {71'd0, bus.frame_done}, {71'd0, m_done});
        check("frame_err", {71'd0, bus.frame_err}, {71'd0, m_err});
        check("in_ready", {71'd0, bus.in_ready}, {71'd0, m_ready});
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_d[i] = 8'h00;
        part_q.delete();
        m_idle = 0; m_commit = 0; m_ready = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_edge(input bit v, input bit s, input logic [7:0] d);
        bit xfer;
        m_done = 0;
        m_err  = 0;
        if (m_commit) begin
            m_d      = m_frame;
            m_done   = 1;
            m_commit = 0;
            m_ready  = 1;
        end else begin
            xfer    = v && m_ready;
            m_ready = 1;
            if (xfer) begin
                m_idle = 0;
                if (s) begin
                    if (part_q.size() > 0) m_err = 1;
                    part_q.delete();
                    part_q.push_back(d);
                end else if (part_q.size() == 0) begin
                    m_err = 1;
                end else begin
                    part_q.push_back(d);
                    if (part_q.size() == 9) begin
                        for (int i = 0; i < 9; i++) m_frame[i] = part_q[i];
                        part_q.delete();
                        m_commit = 1;
                        m_ready  = 0;
                    end
                end
            end else if (part_q.size() > 0) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_err = 1;
                    part_q.delete();
                    m_idle = 0;
                end
            end else begin
                m_idle = 0;
            end
        end
    endtask

    task automatic cycle(input bit v, input bit s, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_data  = d;
        @(posedge clk);
        model_edge(v, s, d);
        #1;
        check_all();
    endtask

    // Holds the byte on the bus until the model says it was taken (bounded).
    task automatic push_byte(input bit s, input logic [7:0] d);
        int tries;
        bit acc;
        tries = 0;
        do begin
            acc = m_ready;
            cycle(1'b1, s, d);
            tries++;
        end while (!acc && tries < 4);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic send_bytes(input logic [71:0] f, input int n);
        for (int i = 0; i < n; i++) push_byte(i == 0, f[71-8*i -: 8]);
    endtask

    task automatic apply_reset();
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = 8'h00;
        model_reset();
        #1;
        apply_reset();

        // Single frame, then a byte offered on the first post-reset edge.
        send_bytes(72'h02_00_00_00_00_00_00_00_00, 9);
        idle(3);

        // Two frames back to back with valid held high.
        send_bytes(72'h11_12_13_14_15_16_17_18_19, 9);
        send_bytes(72'h21_22_23_24_25_26_27_28_29, 9);
        idle(2);

        // Restart on sof after 5 bytes.
        send_bytes(72'h31_32_33_34_35_00_00_00_00, 5);
        send_bytes(72'hAA_B1_B2_B3_B4_B5_B6_B7_B8, 9);
        idle(2);

        // Timeout after 4 bytes, then a normal frame.
        send_bytes(72'h41_42_43_44_00_00_00_00_00, 4);
        idle(TO + 2);
        send_bytes(72'h51_52_53_54_55_56_57_58_59, 9);
        idle(1);

        // Byte arriving exactly on the timeout cycle wins.
        send_bytes(72'h61_62_63_64_00_00_00_00_00, 4);
        idle(TO - 1);
        send_bytes(72'h00_65_66_67_68_69_6A_6B_6C, 9);
        idle(1);

        // Byte without sof while idle.
        push_byte(1'b0, 8'h77);
        idle(2);

        // Reset after 7 bytes, then a full frame.
        send_bytes(72'h81_82_83_84_85_86_87_00_00, 7);
        apply_reset();
        send_bytes(72'h91_92_93_94_95_96_97_98_99, 9);
        idle(2);

        // Randomized traffic including long gaps.
        repeat (400) begin
            int r;
            bit s;
            r = $urandom_range(0, 99);
            if (r < 5) idle($urandom_range(15, 25));
            else if (r < 35) cycle(1'b0, 1'($urandom), 8'($urandom));
            else begin
                s = (part_q.size() == 0) ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 15) == 0);
                push_byte(s, 8'($urandom));
            end
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
